// File: rtl/issue_scheduler_pkg.sv
// Shared types and helpers for the issue scheduler: opcode constants, the
// reservation-station entry layout and the completion-bus tag match.
package issue_scheduler_pkg;

    localparam int PREG_W = 6;
    localparam int ROB_W  = 5;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    typedef struct packed {
        logic              valid;
        logic              is_mem;
        logic [31:0]       instr;
        logic [PREG_W-1:0] ps1;
        logic [PREG_W-1:0] ps2;
        logic [PREG_W-1:0] pd;
        logic [ROB_W-1:0]  rob;
        logic              s1_rdy;
        logic              s2_rdy;
    } rs_entry_t;

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_STORE);
    endfunction

    // Slot 0 carries ALU completions, slot 1 MEM completions; either may match.
    function automatic logic wake_hit(input logic [1:0]        cmp_valid,
                                      input logic [PREG_W-1:0] tag0,
                                      input logic [PREG_W-1:0] tag1,
                                      input logic [PREG_W-1:0] tag);
        return (cmp_valid[0] && (tag0 == tag)) || (cmp_valid[1] && (tag1 == tag));
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Older-than matrix over reservation-station slots; grants the oldest
// requesting slot as a one-hot vector.
module rs_age_matrix #(
    parameter int N = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_alloc,
    input  logic [N-1:0] i_free,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_grant
);

    logic [N-1:0] r_valid;
    logic [N-1:0] r_older [N];

    // Row i holds the slots older than i; freed slots drop out of every row.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < N; i++) begin
                r_older[i] <= '0;
            end
        end else begin
            r_valid <= (r_valid & ~i_free) | i_alloc;
            for (int i = 0; i < N; i++) begin
                if (i_alloc[i]) begin
                    r_older[i] <= r_valid & ~i_free;
                end else begin
                    r_older[i] <= r_older[i] & ~i_free & ~i_alloc;
                end
            end
        end
    end

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < N; i++) begin
            o_grant[i] = i_req[i] & ~(|(r_older[i] & i_req));
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Reservation station with completion-bus wakeup, oldest-ready ALU issue and
// strictly in-order MEM issue.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int RS_ENTRIES = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_flush,
    input  logic                          i_disp_valid,
    output logic                          o_disp_ready,
    input  logic [31:0]                   i_disp_instr,
    input  logic [PREG_W-1:0]             i_disp_ps1,
    input  logic [PREG_W-1:0]             i_disp_ps2,
    input  logic [PREG_W-1:0]             i_disp_pd,
    input  logic [ROB_W-1:0]              i_disp_rob,
    input  logic                          i_disp_s1_rdy,
    input  logic                          i_disp_s2_rdy,
    input  logic [1:0]                    i_cmp_valid,
    input  logic [2*PREG_W-1:0]           i_cmp_pd,
    output logic                          o_alu_valid,
    input  logic                          i_alu_ready,
    output logic [31:0]                   o_alu_instr,
    output logic [PREG_W-1:0]             o_alu_ps1,
    output logic [PREG_W-1:0]             o_alu_ps2,
    output logic [PREG_W-1:0]             o_alu_pd,
    output logic [ROB_W-1:0]              o_alu_rob,
    output logic                          o_mem_valid,
    input  logic                          i_mem_ready,
    output logic [31:0]                   o_mem_instr,
    output logic [PREG_W-1:0]             o_mem_ps1,
    output logic [PREG_W-1:0]             o_mem_ps2,
    output logic [PREG_W-1:0]             o_mem_pd,
    output logic [ROB_W-1:0]              o_mem_rob,
    output logic [$clog2(RS_ENTRIES):0]   o_rs_count
);

    localparam int IW = $clog2(RS_ENTRIES);
    localparam int CW = IW + 1;

    rs_entry_t             r_rs [RS_ENTRIES];
    logic [CW-1:0]         r_count;

    logic [IW-1:0]         w_free_idx;
    logic                  w_accept;
    logic                  w_disp_mem;
    logic                  w_alu_fire;
    logic                  w_mem_fire;
    logic [PREG_W-1:0]     w_tag0;
    logic [PREG_W-1:0]     w_tag1;
    logic [RS_ENTRIES-1:0] w_alloc;
    logic [RS_ENTRIES-1:0] w_alloc_alu;
    logic [RS_ENTRIES-1:0] w_alloc_mem;
    logic [RS_ENTRIES-1:0] w_free;
    logic [RS_ENTRIES-1:0] w_alu_req;
    logic [RS_ENTRIES-1:0] w_mem_req;
    logic [RS_ENTRIES-1:0] w_mem_rdy;
    logic [RS_ENTRIES-1:0] w_alu_grant;
    logic [RS_ENTRIES-1:0] w_mem_oldest;
    logic [RS_ENTRIES-1:0] w_mem_sel;

    assign w_tag0     = i_cmp_pd[PREG_W-1:0];
    assign w_tag1     = i_cmp_pd[2*PREG_W-1:PREG_W];
    assign w_disp_mem = is_mem_op(i_disp_instr[6:0]);
    assign o_rs_count = r_count;

    // Ready depends only on registered state and flush, never on the FU ready inputs.
    always_comb begin
        w_free_idx = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!r_rs[i].valid) begin
                w_free_idx = IW'(i);
            end
        end
        o_disp_ready = (r_count < CW'(RS_ENTRIES)) & ~i_flush;
        w_accept     = i_disp_valid & o_disp_ready;
        w_alloc      = w_accept ? (RS_ENTRIES'(1) << w_free_idx) : '0;
        w_alloc_alu  = w_disp_mem ? '0 : w_alloc;
        w_alloc_mem  = w_disp_mem ? w_alloc : '0;
    end

    always_comb begin
        w_alu_req = '0;
        w_mem_req = '0;
        w_mem_rdy = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_alu_req[i] = r_rs[i].valid & ~r_rs[i].is_mem & r_rs[i].s1_rdy & r_rs[i].s2_rdy;
            w_mem_req[i] = r_rs[i].valid & r_rs[i].is_mem;
            w_mem_rdy[i] = r_rs[i].s1_rdy & r_rs[i].s2_rdy;
        end
    end

    rs_age_matrix #(.N(RS_ENTRIES)) u_alu_age (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_alloc (w_alloc_alu),
        .i_free  (w_free),
        .i_req   (w_alu_req),
        .o_grant (w_alu_grant)
    );

    // Only the oldest MEM entry competes, so loads and stores never pass each other.
    rs_age_matrix #(.N(RS_ENTRIES)) u_mem_age (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_alloc (w_alloc_mem),
        .i_free  (w_free),
        .i_req   (w_mem_req),
        .o_grant (w_mem_oldest)
    );

    assign w_mem_sel   = w_mem_oldest & w_mem_rdy;
    assign o_alu_valid = |w_alu_grant;
    assign o_mem_valid = |w_mem_sel;
    assign w_alu_fire  = o_alu_valid & i_alu_ready;
    assign w_mem_fire  = o_mem_valid & i_mem_ready;
    assign w_free      = i_flush ? '1 : ((w_alu_fire ? w_alu_grant : '0) | (w_mem_fire ? w_mem_sel : '0));

    always_comb begin
        o_alu_instr = '0;
        o_alu_ps1   = '0;
        o_alu_ps2   = '0;
        o_alu_pd    = '0;
        o_alu_rob   = '0;
        o_mem_instr = '0;
        o_mem_ps1   = '0;
        o_mem_ps2   = '0;
        o_mem_pd    = '0;
        o_mem_rob   = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (w_alu_grant[i]) begin
                o_alu_instr = r_rs[i].instr;
                o_alu_ps1   = r_rs[i].ps1;
                o_alu_ps2   = r_rs[i].ps2;
                o_alu_pd    = r_rs[i].pd;
                o_alu_rob   = r_rs[i].rob;
            end
            if (w_mem_sel[i]) begin
                o_mem_instr = r_rs[i].instr;
                o_mem_ps1   = r_rs[i].ps1;
                o_mem_ps2   = r_rs[i].ps2;
                o_mem_pd    = r_rs[i].pd;
                o_mem_rob   = r_rs[i].rob;
            end
        end
    end

    // A same-cycle completion is folded into the dispatched entry so no wakeup is lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_rs[i] <= '0;
            end
        end else if (i_flush) begin
            r_count <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_rs[i] <= '0;
            end
        end else begin
            r_count <= r_count + CW'(w_accept) - CW'(w_alu_fire) - CW'(w_mem_fire);
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (w_free[i]) begin
                    r_rs[i].valid <= 1'b0;
                end else if (w_alloc[i]) begin
                    r_rs[i].valid  <= 1'b1;
                    r_rs[i].is_mem <= w_disp_mem;
                    r_rs[i].instr  <= i_disp_instr;
                    r_rs[i].ps1    <= i_disp_ps1;
                    r_rs[i].ps2    <= i_disp_ps2;
                    r_rs[i].pd     <= i_disp_pd;
                    r_rs[i].rob    <= i_disp_rob;
                    r_rs[i].s1_rdy <= i_disp_s1_rdy | wake_hit(i_cmp_valid, w_tag0, w_tag1, i_disp_ps1);
                    r_rs[i].s2_rdy <= i_disp_s2_rdy | wake_hit(i_cmp_valid, w_tag0, w_tag1, i_disp_ps2);
                end else if (r_rs[i].valid) begin
                    if (wake_hit(i_cmp_valid, w_tag0, w_tag1, r_rs[i].ps1)) begin
                        r_rs[i].s1_rdy <= 1'b1;
                    end
                    if (wake_hit(i_cmp_valid, w_tag0, w_tag1, r_rs[i].ps2)) begin
                        r_rs[i].s2_rdy <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed-vector bench for issue_scheduler: wakeup, age-ordered ALU/MEM issue,
// full/flush boundaries and asynchronous reset.
module tb_issue_scheduler;

    localparam logic [31:0] INSTR_ADD = 32'h00000033;
    localparam logic [31:0] INSTR_SUB = 32'h40000033;
    localparam logic [31:0] INSTR_LW  = 32'h00002003;
    localparam logic [31:0] INSTR_SW  = 32'h00002023;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        dispValid;
    logic        dispReady;
    logic [31:0] dispInstr;
    logic [5:0]  dispPs1;
    logic [5:0]  dispPs2;
    logic [5:0]  dispPd;
    logic [4:0]  dispRob;
    logic        dispS1Rdy;
    logic        dispS2Rdy;
    logic [1:0]  cmpValid;
    logic [11:0] cmpPd;
    logic        aluValid;
    logic        aluReady;
    logic [31:0] aluInstr;
    logic [5:0]  aluPs1;
    logic [5:0]  aluPs2;
    logic [5:0]  aluPd;
    logic [4:0]  aluRob;
    logic        memValid;
    logic        memReady;
    logic [31:0] memInstr;
    logic [5:0]  memPs1;
    logic [5:0]  memPs2;
    logic [5:0]  memPd;
    logic [4:0]  memRob;
    logic [4:0]  rsCount;

    int checkCount = 0;
    int errorCount = 0;

    issue_scheduler #(.RS_ENTRIES(16)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_flush       (flush),
        .i_disp_valid  (dispValid),
        .o_disp_ready  (dispReady),
        .i_disp_instr  (dispInstr),
        .i_disp_ps1    (dispPs1),
        .i_disp_ps2    (dispPs2),
        .i_disp_pd     (dispPd),
        .i_disp_rob    (dispRob),
        .i_disp_s1_rdy (dispS1Rdy),
        .i_disp_s2_rdy (dispS2Rdy),
        .i_cmp_valid   (cmpValid),
        .i_cmp_pd      (cmpPd),
        .o_alu_valid   (aluValid),
        .i_alu_ready   (aluReady),
        .o_alu_instr   (aluInstr),
        .o_alu_ps1     (aluPs1),
        .o_alu_ps2     (aluPs2),
        .o_alu_pd      (aluPd),
        .o_alu_rob     (aluRob),
        .o_mem_valid   (memValid),
        .i_mem_ready   (memReady),
        .o_mem_instr   (memInstr),
        .o_mem_ps1     (memPs1),
        .o_mem_ps2     (memPs2),
        .o_mem_pd      (memPd),
        .o_mem_rob     (memRob),
        .o_rs_count    (rsCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [5:0] ps1,
                                 input logic [5:0] ps2, input logic [5:0] pd, input logic [4:0] rob,
                                 input logic s1, input logic s2);
        dispValid = valid;
        dispInstr = instr;
        dispPs1   = ps1;
        dispPs2   = ps2;
        dispPd    = pd;
        dispRob   = rob;
        dispS1Rdy = s1;
        dispS2Rdy = s2;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 32'h0, 6'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic applyCmp(input logic [1:0] v, input logic [5:0] tag0, input logic [5:0] tag1);
        cmpValid = v;
        cmpPd    = {tag1, tag0};
    endtask

    // Inputs change at posedge+1; outputs are sampled at posedge+3.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        aluReady = 1'b0;
        memReady = 1'b0;
        applyIdle();
        applyCmp(2'b00, 6'd0, 6'd0);
        #12;
        checkOutput("reset_count", 32'(rsCount), 32'd0);
        checkOutput("reset_disp_ready", 32'(dispReady), 32'd1);
        checkOutput("reset_alu_valid", 32'(aluValid), 32'd0);
        checkOutput("reset_mem_valid", 32'(memValid), 32'd0);
        checkOutput("reset_alu_pd", 32'(aluPd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Ready ADD issues the cycle after dispatch.
        aluReady = 1'b1;
        memReady = 1'b1;
        applyStimulus(1'b1, INSTR_ADD, 6'd3, 6'd4, 6'd10, 5'd1, 1'b1, 1'b1);
        settle();
        checkOutput("t1_alu_valid_pre", 32'(aluValid), 32'd0);
        tick();
        applyIdle();
        settle();
        checkOutput("t1_alu_valid", 32'(aluValid), 32'd1);
        checkOutput("t1_alu_pd", 32'(aluPd), 32'd10);
        checkOutput("t1_alu_rob", 32'(aluRob), 32'd1);
        checkOutput("t1_alu_ps1", 32'(aluPs1), 32'd3);
        checkOutput("t1_count1", 32'(rsCount), 32'd1);
        tick();
        settle();
        checkOutput("t1_count0", 32'(rsCount), 32'd0);
        checkOutput("t1_alu_idle", 32'(aluValid), 32'd0);

        // SUB waits for tag 9; a tag differing only in bit 5 must not wake it.
        applyStimulus(1'b1, INSTR_SUB, 6'd9, 6'd2, 6'd11, 5'd2, 1'b0, 1'b1);
        tick();
        applyIdle();
        applyCmp(2'b01, 6'd41, 6'd0);
        settle();
        checkOutput("t2_wait_a", 32'(aluValid), 32'd0);
        tick();
        applyCmp(2'b00, 6'd0, 6'd0);
        settle();
        checkOutput("t2_alias_tag", 32'(aluValid), 32'd0);
        tick();
        applyCmp(2'b01, 6'd9, 6'd0);
        settle();
        checkOutput("t2_wait_b", 32'(aluValid), 32'd0);
        tick();
        applyCmp(2'b00, 6'd0, 6'd0);
        settle();
        checkOutput("t2_woken_valid", 32'(aluValid), 32'd1);
        checkOutput("t2_woken_pd", 32'(aluPd), 32'd11);
        tick();
        applyStimulus(1'b1, INSTR_SUB, 6'd9, 6'd2, 6'd12, 5'd3, 1'b0, 1'b1);
        applyCmp(2'b10, 6'd0, 6'd9);
        settle();
        checkOutput("t2_count_after_issue", 32'(rsCount), 32'd0);
        tick();
        applyIdle();
        applyCmp(2'b00, 6'd0, 6'd0);
        settle();
        checkOutput("t2_insert_ready", 32'(aluValid), 32'd1);
        checkOutput("t2_insert_pd", 32'(aluPd), 32'd12);
        tick();

        // LW (not ready) blocks the younger ready SW.
        applyStimulus(1'b1, INSTR_LW, 6'd20, 6'd0, 6'd21, 5'd4, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, INSTR_SW, 6'd22, 6'd23, 6'd0, 5'd5, 1'b1, 1'b1);
        tick();
        applyIdle();
        settle();
        checkOutput("t3_blocked_a", 32'(memValid), 32'd0);
        checkOutput("t3_count2", 32'(rsCount), 32'd2);
        tick();
        applyCmp(2'b10, 6'd0, 6'd20);
        settle();
        checkOutput("t3_blocked_b", 32'(memValid), 32'd0);
        tick();
        applyCmp(2'b00, 6'd0, 6'd0);
        settle();
        checkOutput("t3_lw_valid", 32'(memValid), 32'd1);
        checkOutput("t3_lw_rob", 32'(memRob), 32'd4);
        checkOutput("t3_lw_pd", 32'(memPd), 32'd21);
        tick();
        settle();
        checkOutput("t3_sw_valid", 32'(memValid), 32'd1);
        checkOutput("t3_sw_rob", 32'(memRob), 32'd5);
        checkOutput("t3_sw_ps2", 32'(memPs2), 32'd23);
        tick();
        settle();
        checkOutput("t3_mem_idle", 32'(memValid), 32'd0);
        checkOutput("t3_count0", 32'(rsCount), 32'd0);

        // Fill all 16 slots with ops waiting on tags 32..47.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, INSTR_ADD, 6'(32 + i), 6'd1, 6'(i), 5'(i), 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b1, INSTR_ADD, 6'd1, 6'd1, 6'd60, 5'd0, 1'b1, 1'b1);
        settle();
        checkOutput("t4_full_ready", 32'(dispReady), 32'd0);
        checkOutput("t4_full_count", 32'(rsCount), 32'd16);
        checkOutput("t4_full_alu_idle", 32'(aluValid), 32'd0);
        tick();
        applyIdle();
        applyCmp(2'b01, 6'd37, 6'd0);
        settle();
        checkOutput("t4_rejected_count", 32'(rsCount), 32'd16);
        tick();
        applyCmp(2'b00, 6'd0, 6'd0);
        settle();
        checkOutput("t4_e5_valid", 32'(aluValid), 32'd1);
        checkOutput("t4_e5_pd", 32'(aluPd), 32'd5);
        checkOutput("t4_full_fire_ready", 32'(dispReady), 32'd0);
        tick();
        settle();
        checkOutput("t4_after_fire_count", 32'(rsCount), 32'd15);
        checkOutput("t4_after_fire_ready", 32'(dispReady), 32'd1);
        applyStimulus(1'b1, INSTR_ADD, 6'd50, 6'd1, 6'd50, 5'd20, 1'b0, 1'b1);
        tick();
        applyIdle();
        applyCmp(2'b11, 6'd50, 6'd35);
        settle();
        checkOutput("t4_refill_count", 32'(rsCount), 32'd16);
        tick();
        applyCmp(2'b00, 6'd0, 6'd0);
        settle();
        checkOutput("t4_older_first", 32'(aluPd), 32'd3);
        tick();
        settle();
        checkOutput("t4_new_youngest", 32'(aluPd), 32'd50);
        tick();
        settle();
        checkOutput("t4_count14", 32'(rsCount), 32'd14);
        flush = 1'b1;
        settle();
        checkOutput("t4_flush_ready", 32'(dispReady), 32'd0);
        tick();
        flush = 1'b0;
        settle();
        checkOutput("t4_flush_count", 32'(rsCount), 32'd0);

        // A, B, C held under backpressure, then drained with a parallel MEM issue.
        aluReady = 1'b0;
        memReady = 1'b0;
        applyStimulus(1'b1, INSTR_ADD, 6'd1, 6'd2, 6'd40, 5'd10, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, INSTR_ADD, 6'd1, 6'd2, 6'd41, 5'd11, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, INSTR_ADD, 6'd1, 6'd2, 6'd42, 5'd12, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, INSTR_LW, 6'd1, 6'd0, 6'd43, 5'd13, 1'b1, 1'b1);
        tick();
        applyIdle();
        for (int i = 0; i < 4; i++) begin
            settle();
            checkOutput("t5_hold_pd", 32'(aluPd), 32'd40);
            tick();
        end
        aluReady = 1'b1;
        memReady = 1'b1;
        settle();
        checkOutput("t5_a_pd", 32'(aluPd), 32'd40);
        checkOutput("t5_mem_pd", 32'(memPd), 32'd43);
        tick();
        settle();
        checkOutput("t5_b_pd", 32'(aluPd), 32'd41);
        checkOutput("t5_mem_done", 32'(memValid), 32'd0);
        checkOutput("t5_count2", 32'(rsCount), 32'd2);
        tick();
        settle();
        checkOutput("t5_c_pd", 32'(aluPd), 32'd42);
        tick();
        settle();
        checkOutput("t5_drained", 32'(aluValid), 32'd0);
        checkOutput("t5_count0", 32'(rsCount), 32'd0);

        // Flush with 7 waiting entries drops a same-cycle dispatch too.
        aluReady = 1'b0;
        memReady = 1'b0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, INSTR_ADD, 6'(32 + i), 6'd1, 6'(i), 5'(i), 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b1, INSTR_ADD, 6'd1, 6'd1, 6'd33, 5'd7, 1'b1, 1'b1);
        flush = 1'b1;
        settle();
        checkOutput("t6_count7", 32'(rsCount), 32'd7);
        tick();
        flush = 1'b0;
        applyIdle();
        settle();
        checkOutput("t6_flush_count", 32'(rsCount), 32'd0);
        checkOutput("t6_flush_alu", 32'(aluValid), 32'd0);
        checkOutput("t6_flush_ready", 32'(dispReady), 32'd1);

        // Asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, INSTR_ADD, 6'd1, 6'd1, 6'(i + 1), 5'(i), 1'b1, 1'b1);
            tick();
        end
        applyIdle();
        settle();
        checkOutput("t6_pre_reset_count", 32'(rsCount), 32'd3);
        checkOutput("t6_pre_reset_alu", 32'(aluValid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_count", 32'(rsCount), 32'd0);
        checkOutput("t6_async_alu", 32'(aluValid), 32'd0);
        checkOutput("t6_async_pd", 32'(aluPd), 32'd0);
        checkOutput("t6_async_ready", 32'(dispReady), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        settle();
        checkOutput("t6_post_reset_count", 32'(rsCount), 32'd0);
        checkOutput("t6_post_reset_alu", 32'(aluValid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
